// File: rtl/mdu_if.sv
// mdu_if: request/response bundle between the EXE stage and the iterative
// multiply/divide unit.
//   master (EXE side)  : drives in_valid, op, src1, src2, cancel, out_ready
//   slave  (unit side) : drives in_ready, out_valid, res_hi, res_lo, div_by_zero
interface mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_by_zero;

  modport master (
    output in_valid, op, src1, src2, cancel, out_ready,
    input  in_ready, out_valid, res_hi, res_lo, div_by_zero
  );

  modport slave (
    input  in_valid, op, src1, src2, cancel, out_ready,
    output in_ready, out_valid, res_hi, res_lo, div_by_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit returning a HI/LO pair.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : mdu_if slave port
//            in_valid/in_ready/op/src1/src2 : request handshake and operands
//            cancel                         : flush of the in-flight operation
//            out_valid/out_ready            : result handshake
//            res_hi/res_lo/div_by_zero      : registered result
// Multiply completes in one MUL cycle; divide is a restoring divider on the
// operand magnitudes producing one quotient bit per cycle, followed by a FIX
// cycle that applies signs and the divide-by-zero convention.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0]       OP_DIV   = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Two's complement negation.
  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of v when treated as signed, otherwise v unchanged.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return neg2(v);
    end else begin
      return v;
    end
  endfunction

  // Sign- or zero-extension to the full product width.
  function automatic logic [2*WIDTH-1:0] ext(input logic [WIDTH-1:0] v, input logic is_signed);
    return {{WIDTH{is_signed & v[WIDTH-1]}}, v};
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   rem_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   dvs_r;
  logic [WIDTH-1:0]   res_hi_r;
  logic [WIDTH-1:0]   res_lo_r;
  logic               dbz_r;
  logic               out_valid_r;

  logic               in_ready_s;
  logic               accept_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     diff_s;
  logic               qbit_s;
  logic [WIDTH-1:0]   rem_nxt_s;
  logic               dbz_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; cancel overrides everything except reset.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.cancel) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nxt_s = bus.op[1] ? ST_DIV : ST_MUL;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MUL:  state_nxt_s = ST_DONE;
        ST_DIV: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_DIV;
          end
        end
        ST_FIX:  state_nxt_s = ST_DONE;
        ST_DONE: begin
          // Handshake completes; a new request may be taken in the same cycle.
          if (accept_s) begin
            state_nxt_s = bus.op[1] ? ST_DIV : ST_MUL;
          end else if (bus.out_ready) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs: ready in IDLE, or in DONE when the result is being taken.
  always_comb begin
    in_ready_s = 1'b0;
    if (bus.cancel) begin
      in_ready_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      in_ready_s = 1'b1;
    end else if (state_r == ST_DONE) begin
      in_ready_s = bus.out_ready;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = in_ready_s & bus.in_valid;
  end

  // Product and one restoring-division step from the captured operands.
  always_comb begin
    // op_r[0]=0 selects the signed variant (MULT).
    prod_s    = ext(a_r, ~op_r[0]) * ext(b_r, ~op_r[0]);
    shift_s   = {rem_r, quo_r[WIDTH-1]};
    diff_s    = shift_s - {1'b0, dvs_r};
    qbit_s    = ~diff_s[WIDTH];
    rem_nxt_s = shift_s[WIDTH-1:0];
    if (qbit_s) begin
      rem_nxt_s = diff_s[WIDTH-1:0];
    end else begin
      rem_nxt_s = shift_s[WIDTH-1:0];
    end
  end

  // Sign fix-up and divide-by-zero override applied in FIX.
  always_comb begin
    dbz_s    = (b_r == {WIDTH{1'b0}});
    fix_hi_s = rem_r;
    fix_lo_s = quo_r;
    if (dbz_s) begin
      fix_lo_s = {WIDTH{1'b1}};
      fix_hi_s = a_r;
    end else if (op_r == OP_DIV) begin
      fix_lo_s = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? neg2(quo_r) : quo_r;
      fix_hi_s = a_r[WIDTH-1] ? neg2(rem_r) : rem_r;
    end else begin
      fix_lo_s = quo_r;
      fix_hi_s = rem_r;
    end
  end

  // Operand capture at accept only; later changes on src1/src2 are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= 2'b00;
      a_r  <= {WIDTH{1'b0}};
      b_r  <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      op_r <= bus.op;
      a_r  <= bus.src1;
      b_r  <= bus.src2;
    end
  end

  // Iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (bus.cancel || accept_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_DIV) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Divider datapath: quo_r starts as the dividend magnitude and is shifted
  // out MSB first while quotient bits shift in from the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r <= {WIDTH{1'b0}};
      quo_r <= {WIDTH{1'b0}};
      dvs_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      rem_r <= {WIDTH{1'b0}};
      quo_r <= mag(bus.src1, bus.op == OP_DIV);
      dvs_r <= mag(bus.src2, bus.op == OP_DIV);
    end else if ((state_r == ST_DIV) && !bus.cancel) begin
      rem_r <= rem_nxt_s;
      quo_r <= {quo_r[WIDTH-2:0], qbit_s};
    end
  end

  // Result registers; a cancelled operation leaves the previous values.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_hi_r <= {WIDTH{1'b0}};
      res_lo_r <= {WIDTH{1'b0}};
      dbz_r    <= 1'b0;
    end else if ((state_r == ST_MUL) && !bus.cancel) begin
      res_hi_r <= prod_s[2*WIDTH-1:WIDTH];
      res_lo_r <= prod_s[WIDTH-1:0];
      dbz_r    <= 1'b0;
    end else if ((state_r == ST_FIX) && !bus.cancel) begin
      res_hi_r <= fix_hi_s;
      res_lo_r <= fix_lo_s;
      dbz_r    <= dbz_s;
    end
  end

  // Registered out_valid tracks entry into and residence in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.res_hi      = res_hi_r;
  assign bus.res_lo      = res_lo_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (WIDTH=32). Directed table,
// randomized operations against an arithmetic reference model, and
// hand-written cancel / hold / back-to-back sequences.
module tb_mdu_iter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mdu_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    dbz = 1'b0;
    hi  = 32'd0;
    lo  = 32'd0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; {hi, lo} = p; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF; hi = a; dbz = 1'b1;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  // Present one request at posedge+1 with the unit idle; returns the result
  // and the number of cycles from presentation to out_valid (cycle 0 = request).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                        output int lat);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.src1     = a;
    bus.src2     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op       = 2'($urandom_range(0, 3));
    bus.src1     = $urandom;
    bus.src2     = $urandom;
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
    end
    hi  = bus.res_hi;
    lo  = bus.res_lo;
    dbz = bus.div_by_zero;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] hi, lo, ehi, elo;
    logic        dbz, edbz;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          lat;

    checks   = 0;
    failures = 0;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2};
    vecs[1] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 2};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[3] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 34};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
    vecs[5] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 34};
    vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 2};
    vecs[8] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 34};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.src1      = 32'd0;
    bus.src2      = 32'd0;
    bus.cancel    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_res_hi", bus.res_hi, 32'd0);
    chk("rst_res_lo", bus.res_lo, 32'd0);
    chk("rst_dbz", bus.div_by_zero, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dbz, lat);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      @(negedge clk);
      chk($sformatf("vec%0d_idle", i), {bus.in_ready, bus.out_valid}, 2'b10);
      @(posedge clk); #1;
    end

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      model(op, a, b, ehi, elo, edbz);
      run_op(op, a, b, hi, lo, dbz, lat);
      chk($sformatf("rnd%0d_op%0d_%h_%h_hi", i, op, a, b), hi, ehi);
      chk($sformatf("rnd%0d_op%0d_%h_%h_lo", i, op, a, b), lo, elo);
      chk($sformatf("rnd%0d_dbz", i), dbz, edbz);
      chk($sformatf("rnd%0d_lat", i), lat, op[1] ? 34 : 2);
    end

    // Cancel during a divide, request held during the cancel cycle.
    bus.in_valid = 1'b1; bus.op = 2'b10; bus.src1 = 32'd1000; bus.src2 = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    bus.in_valid = 1'b1; bus.op = 2'b01; bus.src1 = 32'd7; bus.src2 = 32'd7;
    @(negedge clk);
    chk("cancel_in_ready", bus.in_ready, 1'b0);
    chk("cancel_out_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    bus.src1 = 32'd3; bus.src2 = 32'd5;
    @(negedge clk);
    chk("cancel_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("cancel_mul_busy", bus.out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("cancel_mul_valid", bus.out_valid, 1'b1);
    chk("cancel_mul_res", {bus.res_hi, bus.res_lo, bus.div_by_zero}, {32'd0, 32'd15, 1'b0});
    @(posedge clk); #1;

    // Hold in DONE for 5 cycles, then back-to-back accept on release.
    bus.out_ready = 1'b0;
    a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    model(2'b01, a, b, ehi, elo, edbz);
    bus.in_valid = 1'b1; bus.op = 2'b01; bus.src1 = a; bus.src2 = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("hold_lat", lat, 2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold%0d", k), {bus.out_valid, bus.in_ready, bus.res_hi, bus.res_lo},
          {1'b1, 1'b0, ehi, elo});
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = 2'b11; bus.src1 = 32'd100; bus.src2 = 32'd7;
    #1;
    chk("b2b_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.src1 = $urandom; bus.src2 = $urandom;
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("b2b_lat", lat, 34);
    chk("b2b_res", {bus.res_hi, bus.res_lo, bus.div_by_zero}, {32'd2, 32'd14, 1'b0});
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Iterative multiply/divide unit for the EXE stage of the MIPS pipeline, replacing the vendor divider IP and the inline multipliers. It performs MULT/MULTU/DIV/DIVU at a parametrised width and returns a HI/LO pair through valid/ready handshakes. A synchronous cancel lets the EXE stage kill an in-flight operation on exception or ERET flush. EXE holds its ready_go low until out_valid and writes HI/LO only on the output handshake.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; divide takes WIDTH iteration cycles.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operation request.
in_ready  output  1  unit can accept a request this cycle.
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
src1  input  WIDTH  rs value: multiplicand or dividend.
src2  input  WIDTH  rt value: multiplier or divisor.
cancel  input  1  flush; abort the current operation.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
res_hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder.
res_lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient.
div_by_zero  output  1  the held result came from a divide with src2==0.

Behaviour:
- Reset: state IDLE; out_valid=0; res_hi=0; res_lo=0; div_by_zero=0; counter=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- in_ready = ~cancel & (IDLE | (DONE & out_ready)).
- Accept: in_valid & in_ready at an edge latches op, src1 and src2.
  - op[1]=0: next state MUL.
  - op[1]=1: next state DIV with counter=0.
- MUL: one cycle; full 2W-bit product, signed or unsigned per op[0]. Result registers load at the edge leaving MUL; next state DONE.
- Multiply latency: accept edge E; out_valid=1 from edge E+2.
- DIV:
  - Restoring division on the magnitudes |src1| and |src2|; magnitudes are used only when op=DIV.
  - One quotient bit per cycle, MSB first; counter increments each cycle.
  - When counter==WIDTH-1, next state FIX.
- FIX:
  - Quotient is negated if sign(src1)^sign(src2) for signed DIV.
  - Remainder takes the sign of src1.
  - Result registers load; next state DONE.
- Divide latency: out_valid=1 from edge E+WIDTH+2.
- Divide by zero (src2==0):
  - Runs the full latency.
  - res_lo = all ones; res_hi = src1 unmodified; div_by_zero=1.
  - div_by_zero is 0 for every other result.
- Signed overflow (src1 = -2^(W-1), src2 = -1): res_lo = 0x80..0, res_hi = 0; no flag.
- DONE:
  - out_valid=1; res_* and div_by_zero are held stable while out_ready=0.
  - On out_ready: out_valid drops at the next edge, or a new request is accepted in the same cycle (back-to-back).
- cancel:
  - In any state, the next edge forces IDLE, out_valid=0 and counter=0.
  - No input is accepted in a cancel cycle.
  - res_*/div_by_zero keep their previous values but are never presented as valid.
  - cancel in the same cycle as an output handshake: the handshake completes; EXE ignores the result.
- Priority: reset > cancel > output handshake > accept > iteration.
- Operands are captured only at accept; src1/src2 may change during iteration without effect.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, out_ready=1 -> out_valid at E+2; HI=0xFFFFFFFE, LO=0x00000001; then in_ready=1.
- MULT 0xFFFFFFFE*0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV -7/2, i.e. 0xFFFFFFF9/0x00000002 -> out_valid at exactly E+34; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x00000064, div_by_zero=1.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV accepted, then cancel pulsed at E+10:
  - out_valid stays 0 and state returns to IDLE at E+11.
  - MULTU 3*5 accepted at E+11 -> LO=15 at E+13.
  - out_ready held 0 for 5 cycles in DONE -> outputs are held stable, followed by a back-to-back accept on release.
